// File: rtl/drcp_pkg.sv
// rtl/drcp_pkg.sv - shared ITCM types, address map and FSM state encoding
// Contents: ITCM_BASE/ITCM_SIZE/ITCM_END address map, ITCM_ADDR_W word-address width,
// inst_req_t/inst_ack_t fetch structs, itcm_rsp_state_t FSM enum, address helpers.
package drcp_pkg;

    localparam logic [31:0] ITCM_BASE   = 32'h0001_0000;
    localparam int unsigned ITCM_SIZE   = 65536;
    localparam logic [31:0] ITCM_END    = ITCM_BASE + 32'(ITCM_SIZE) - 32'd1;
    localparam int          ITCM_ADDR_W = $clog2(ITCM_SIZE / 4);

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
    } inst_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] data;
    } inst_ack_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ERR
    } itcm_rsp_state_t;

    // Inside the ITCM window and word aligned.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a >= ITCM_BASE) && (a <= ITCM_END) && (a[1:0] == 2'b00);
    endfunction

    // Byte address to SRAM word index, relative to the window base.
    function automatic logic [ITCM_ADDR_W-1:0] word_addr(input logic [31:0] a);
        return ITCM_ADDR_W'((a - ITCM_BASE) >> 2);
    endfunction

endpackage

// File: rtl/itcm_inst_rsp_if.sv
// rtl/itcm_inst_rsp_if.sv - instruction fetch request/response bundle
// Signals: inst_req (core -> ITCM: level req + addr), inst_ack (ITCM -> core: ack pulse,
// error, data). Modports: master = core side, slave = ITCM responder side.
interface itcm_inst_rsp_if;
    import drcp_pkg::*;

    inst_req_t inst_req;
    inst_ack_t inst_ack;

    modport master (output inst_req, input inst_ack);
    modport slave  (input inst_req, output inst_ack);
endinterface

// File: rtl/itcm_inst_rsp_sram.sv
// rtl/itcm_inst_rsp_sram.sv - behavioural single-port SRAM, 1-cycle registered read
// Ports: clk_i, en_i (access), we_i (1 = write), addr_i (word index), wdata_i, rdata_o
// (valid the cycle after a read access, held until the next read).
module itcm_sram #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end
endmodule

// File: rtl/itcm_inst_rsp.sv
// rtl/itcm_inst_rsp.sv - ITCM fetch responder with program-loader write port
// Ports: clk_i, rst_ni (async, active-low); fetch (slave: inst_req in, inst_ack out);
// ld_we_i/ld_addr_i/ld_wdata_i loader write in, ld_gnt_o grant; sram_en_o/sram_we_o/
// sram_addr_o/sram_wdata_o SRAM command out, sram_rdata_i SRAM read data in.
module itcm_inst_rsp
    import drcp_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    itcm_inst_rsp_if.slave         fetch,
    input  logic                   ld_we_i,
    input  logic [31:0]            ld_addr_i,
    input  logic [31:0]            ld_wdata_i,
    output logic                   ld_gnt_o,
    output logic                   sram_en_o,
    output logic                   sram_we_o,
    output logic [ITCM_ADDR_W-1:0] sram_addr_o,
    output logic [31:0]            sram_wdata_o,
    input  logic [31:0]            sram_rdata_i
);
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    itcm_rsp_state_t state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rd_pend_q;   // SRAM read issued last cycle; rdata valid now
    logic [31:0]     data_q;
    logic            gnt, en, we, use_ld;
    inst_ack_t       ack;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        en      = 1'b0;
        we      = 1'b0;
        use_ld  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Loader wins; a concurrent fetch simply waits in IDLE.
                if (ld_we_i) begin
                    gnt    = 1'b1;
                    use_ld = 1'b1;
                    if (addr_legal(ld_addr_i)) begin
                        en = 1'b1;
                        we = 1'b1;
                    end
                end else if (fetch.inst_req.req) begin
                    if (addr_legal(fetch.inst_req.addr)) begin
                        en      = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Reset must silence the SRAM/loader strobes even though IDLE would raise them.
    assign ld_gnt_o     = rst_ni & gnt;
    assign sram_en_o    = rst_ni & en;
    assign sram_we_o    = rst_ni & we;
    assign sram_addr_o  = word_addr(use_ld ? ld_addr_i : fetch.inst_req.addr);
    assign sram_wdata_o = ld_wdata_i;

    always_comb begin
        ack = '0;
        case (state_q)
            S_RESP: begin
                ack.ack  = 1'b1;
                // With no wait states the read lands in the RESP cycle itself.
                ack.data = rd_pend_q ? sram_rdata_i : data_q;
            end
            S_ERR: begin
                ack.ack   = 1'b1;
                ack.error = 1'b1;
            end
            default: ack = '0;
        endcase
    end

    assign fetch.inst_ack = ack;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            rd_pend_q <= 1'b0;
            data_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= en & ~we;
            if (rd_pend_q) begin
                data_q <= sram_rdata_i;
            end
        end
    end
endmodule

// File: tb/tb_itcm_inst_rsp.sv
// tb/tb_itcm_inst_rsp.sv - directed bench for itcm_inst_rsp at WAIT_CYCLES 0, 2 and 3
module tb_itcm_inst_rsp;
    import drcp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_s;
    logic [31:0] addr_s;
    logic        ld_we_s;
    logic [31:0] ld_addr_s;
    logic [31:0] ld_wdata_s;
    int          sel;
    int          n_vec;
    int          n_err;

    inst_ack_t                ack_v   [3];
    logic                     gnt_v   [3];
    logic                     en_v    [3];
    logic                     we_v    [3];
    logic [ITCM_ADDR_W-1:0]   saddr_v [3];
    logic [31:0]              wdata_v [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance g has WAIT_CYCLES 0, 2, 3; sel routes the shared stimulus to one of them.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        itcm_inst_rsp_if fif ();
        logic [31:0] rdata;

        assign fif.inst_req = inst_req_t'{req: req_s && (sel == g), addr: addr_s};
        assign ack_v[g]     = fif.inst_ack;

        itcm_inst_rsp #(.WAIT_CYCLES((g == 0) ? 0 : g + 1)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .fetch        (fif.slave),
            .ld_we_i      (ld_we_s && (sel == g)),
            .ld_addr_i    (ld_addr_s),
            .ld_wdata_i   (ld_wdata_s),
            .ld_gnt_o     (gnt_v[g]),
            .sram_en_o    (en_v[g]),
            .sram_we_o    (we_v[g]),
            .sram_addr_o  (saddr_v[g]),
            .sram_wdata_o (wdata_v[g]),
            .sram_rdata_i (rdata)
        );

        itcm_sram #(.AW(ITCM_ADDR_W)) u_sram (
            .clk_i   (clk),
            .en_i    (en_v[g]),
            .we_i    (we_v[g]),
            .addr_i  (saddr_v[g]),
            .wdata_i (wdata_v[g]),
            .rdata_o (rdata)
        );
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we_s    = 1'b1;
        ld_addr_s  = a;
        ld_wdata_s = d;
        @(negedge clk);
        ld_we_s = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        rst_n     = 1'b0;
        ld_we_s   = 1'b1;
        ld_addr_s = 32'h0001_0000;
        req_s     = 1'b1;
        addr_s    = 32'h0001_0000;
        #1;
        n_vec++; if (gnt_v[0] !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b want 0", gnt_v[0]); end
        n_vec++; if (en_v[0] !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", en_v[0]); end
        n_vec++; if (we_v[0] !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", we_v[0]); end
        n_vec++; if (ack_v[0] !== '0) begin n_err++; $display("FAIL rst_ack: got %h want 0", ack_v[0]); end
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (ack_v[2] !== '0) begin n_err++; $display("FAIL rst_ack_w3: got %h want 0", ack_v[2]); end
        ld_we_s = 1'b0;
        req_s   = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_fetch_w0();
        sel = 0;
        load(32'h0001_0000, 32'h0000_0013);
        @(negedge clk);
        req_s  = 1'b1;
        addr_s = 32'h0001_0000;
        #1;
        n_vec++; if (en_v[0] !== 1'b1 || we_v[0] !== 1'b0) begin n_err++; $display("FAIL w0_rd_t: got en=%b we=%b want en=1 we=0", en_v[0], we_v[0]); end
        n_vec++; if (saddr_v[0] !== 14'h0000) begin n_err++; $display("FAIL w0_saddr: got %h want 0000", saddr_v[0]); end
        n_vec++; if (ack_v[0].ack !== 1'b0) begin n_err++; $display("FAIL w0_ack_t: got %b want 0", ack_v[0].ack); end
        @(negedge clk);
        req_s = 1'b0;
        #1;
        n_vec++; if (ack_v[0] !== {1'b1, 1'b0, 32'h0000_0013}) begin n_err++; $display("FAIL w0_ack_t1: got %h want 200000013", ack_v[0]); end
        n_vec++; if (en_v[0] !== 1'b0) begin n_err++; $display("FAIL w0_en_t1: got %b want 0", en_v[0]); end
        @(negedge clk);
        #1;
        n_vec++; if (ack_v[0] !== '0) begin n_err++; $display("FAIL w0_idle_t2: got %h want 0", ack_v[0]); end
    endtask

    task automatic test_wait2();
        sel = 1;
        load(32'h0001_fffc, 32'hA5A5_1234);
        @(negedge clk);
        req_s  = 1'b1;
        addr_s = 32'h0001_fffc;
        #1;
        n_vec++; if (saddr_v[1] !== 14'h3fff) begin n_err++; $display("FAIL w2_saddr: got %h want 3fff", saddr_v[1]); end
        n_vec++; if (en_v[1] !== 1'b1 || we_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_rd_t: got en=%b we=%b want en=1 we=0", en_v[1], we_v[1]); end
        @(negedge clk);
        ld_we_s    = 1'b1;
        ld_addr_s  = 32'h0001_0008;
        ld_wdata_s = 32'h1122_3344;
        #1;
        n_vec++; if (ack_v[1].ack !== 1'b0) begin n_err++; $display("FAIL w2_ack_t1: got %b want 0", ack_v[1].ack); end
        n_vec++; if (gnt_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_gnt_t1: got %b want 0", gnt_v[1]); end
        @(negedge clk);
        #1;
        n_vec++; if (ack_v[1].ack !== 1'b0) begin n_err++; $display("FAIL w2_ack_t2: got %b want 0", ack_v[1].ack); end
        n_vec++; if (gnt_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_gnt_t2: got %b want 0", gnt_v[1]); end
        @(negedge clk);
        req_s = 1'b0;
        #1;
        n_vec++; if (ack_v[1] !== {1'b1, 1'b0, 32'hA5A5_1234}) begin n_err++; $display("FAIL w2_ack_t3: got %h want 2a5a51234", ack_v[1]); end
        n_vec++; if (gnt_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_gnt_t3: got %b want 0", gnt_v[1]); end
        @(negedge clk);
        #1;
        n_vec++; if (ack_v[1].ack !== 1'b0) begin n_err++; $display("FAIL w2_ack_t4: got %b want 0", ack_v[1].ack); end
        n_vec++; if (gnt_v[1] !== 1'b1 || en_v[1] !== 1'b1 || we_v[1] !== 1'b1) begin n_err++; $display("FAIL w2_ld_t4: got gnt=%b en=%b we=%b want 1 1 1", gnt_v[1], en_v[1], we_v[1]); end
        n_vec++; if (saddr_v[1] !== 14'h0002) begin n_err++; $display("FAIL w2_ld_saddr: got %h want 0002", saddr_v[1]); end
        @(negedge clk);
        ld_we_s = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h0002_0000;
        bad[1] = 32'h0001_0002;
        bad[2] = 32'h0000_fffc;
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_s  = 1'b1;
            addr_s = bad[i];
            #1;
            n_vec++; if (en_v[0] !== 1'b0) begin n_err++; $display("FAIL ill_en_t[%0d]: got %b want 0", i, en_v[0]); end
            @(negedge clk);
            req_s = 1'b0;
            #1;
            n_vec++; if (ack_v[0] !== {1'b1, 1'b1, 32'h0}) begin n_err++; $display("FAIL ill_ack[%0d]: got %h want 300000000", i, ack_v[0]); end
            n_vec++; if (en_v[0] !== 1'b0) begin n_err++; $display("FAIL ill_en_t1[%0d]: got %b want 0", i, en_v[0]); end
        end
        @(negedge clk);
        ld_we_s    = 1'b1;
        ld_addr_s  = 32'h0002_0000;
        ld_wdata_s = 32'hFFFF_FFFF;
        #1;
        n_vec++; if (gnt_v[0] !== 1'b1) begin n_err++; $display("FAIL ill_ld_gnt: got %b want 1", gnt_v[0]); end
        n_vec++; if (en_v[0] !== 1'b0) begin n_err++; $display("FAIL ill_ld_en: got %b want 0", en_v[0]); end
        @(negedge clk);
        ld_we_s = 1'b0;
    endtask

    task automatic test_loader_priority();
        sel = 0;
        @(negedge clk);
        ld_we_s    = 1'b1;
        ld_addr_s  = 32'h0001_0004;
        ld_wdata_s = 32'hDEAD_BEEF;
        req_s      = 1'b1;
        addr_s     = 32'h0001_0004;
        #1;
        n_vec++; if (gnt_v[0] !== 1'b1 || en_v[0] !== 1'b1 || we_v[0] !== 1'b1) begin n_err++; $display("FAIL pri_wr: got gnt=%b en=%b we=%b want 1 1 1", gnt_v[0], en_v[0], we_v[0]); end
        n_vec++; if (wdata_v[0] !== 32'hDEAD_BEEF || saddr_v[0] !== 14'h0001) begin n_err++; $display("FAIL pri_wr_bus: got wdata=%h addr=%h want deadbeef 0001", wdata_v[0], saddr_v[0]); end
        @(negedge clk);
        ld_we_s = 1'b0;
        #1;
        n_vec++; if (ack_v[0].ack !== 1'b0) begin n_err++; $display("FAIL pri_ack_early: got %b want 0", ack_v[0].ack); end
        n_vec++; if (gnt_v[0] !== 1'b0 || en_v[0] !== 1'b1 || we_v[0] !== 1'b0) begin n_err++; $display("FAIL pri_rd: got gnt=%b en=%b we=%b want 0 1 0", gnt_v[0], en_v[0], we_v[0]); end
        @(negedge clk);
        req_s = 1'b0;
        #1;
        n_vec++; if (ack_v[0] !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL pri_ack: got %h want 2deadbeef", ack_v[0]); end
    endtask

    task automatic test_reset_in_wait();
        sel = 2;
        load(32'h0001_0010, 32'hCAFE_F00D);
        @(negedge clk);
        req_s  = 1'b1;
        addr_s = 32'h0001_0010;
        @(negedge clk);
        rst_n = 1'b0;
        req_s = 1'b0;
        #1;
        n_vec++; if (ack_v[2] !== '0 || en_v[2] !== 1'b0 || gnt_v[2] !== 1'b0) begin n_err++; $display("FAIL rw_zero: got ack=%h en=%b gnt=%b want 0", ack_v[2], en_v[2], gnt_v[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_vec++; if (ack_v[2].ack !== 1'b0) begin n_err++; $display("FAIL rw_noack[%0d]: got %b want 0", k, ack_v[2].ack); end
        end
        @(negedge clk);
        req_s = 1'b1;
        #1;
        n_vec++; if (en_v[2] !== 1'b1) begin n_err++; $display("FAIL rw_refetch_en: got %b want 1", en_v[2]); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            n_vec++; if (ack_v[2].ack !== 1'b0) begin n_err++; $display("FAIL rw_wait_ack[%0d]: got %b want 0", k, ack_v[2].ack); end
        end
        @(negedge clk);
        #1;
        n_vec++; if (ack_v[2] !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin n_err++; $display("FAIL rw_ack: got %h want 2cafef00d", ack_v[2]); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (ack_v[2] !== '0) begin n_err++; $display("FAIL rw_resp_rst: got %h want 0", ack_v[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        req_s = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp;
        sel    = 0;
        addr_s = 32'h0001_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_s = (c < 6);
            #1;
            exp = (c == 1) || (c == 3) || (c == 5);
            n_vec++; if (ack_v[0].ack !== exp) begin n_err++; $display("FAIL b2b_ack[%0d]: got %b want %b", c, ack_v[0].ack, exp); end
            if (exp) begin
                n_vec++; if (ack_v[0].data !== 32'h0000_0013) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want 00000013", c, ack_v[0].data); end
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        sel        = 0;
        rst_n      = 1'b0;
        req_s      = 1'b0;
        addr_s     = 32'h0;
        ld_we_s    = 1'b0;
        ld_addr_s  = 32'h0;
        ld_wdata_s = 32'h0;
        test_reset();
        test_fetch_w0();
        test_wait2();
        test_illegal();
        test_loader_priority();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/itcm_inst_rsp.md
ITCM_INST_RSP -- requirements
Module: itcm_inst_rsp

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 0, extra SRAM read wait states, legal range 0..7.
REQ-002 SHALL have port: clk_i  input  1  the block's single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: inst_req_i  input  inst_req_t  fetch request from the core.
- req: level signal.
- addr: held stable until ack.
REQ-005 SHALL have port: inst_ack_o  output  inst_ack_t  fetch response.
- ack: one-cycle pulse.
- error: qualified by ack.
- data: qualified by ack.
REQ-006 SHALL have port: ld_we_i  input  1  program-loader write request.
REQ-007 SHALL have port: ld_addr_i  input  32  loader byte address.
REQ-008 SHALL have port: ld_wdata_i  input  32  loader write word.
REQ-009 SHALL have port: ld_gnt_o  output  1  loader write accepted this cycle.
REQ-010 SHALL have port: sram_en_o  output  1  SRAM access enable.
REQ-011 SHALL have port: sram_we_o  output  1  SRAM write enable.
REQ-012 SHALL have port: sram_addr_o  output  ITCM_ADDR_W  SRAM word address.
REQ-013 SHALL have port: sram_wdata_o  output  32  SRAM write data.
REQ-014 SHALL have port: sram_rdata_i  input  32  SRAM read data, valid 1 cycle after en with we=0.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP, ERR.
REQ-016 SHALL treat an address as legal iff ITCM_BASE <= addr <= ITCM_END and addr[1:0]==0.
REQ-017 SHALL set sram_addr_o = (addr - ITCM_BASE)[ITCM_ADDR_W+1:2], combinationally, for both fetch and loader accesses.
REQ-018 IDLE with ld_we_i=1 SHALL do the following, all in the same cycle:
- assert ld_gnt_o, sram_en_o and sram_we_o;
- drive sram_wdata_o = ld_wdata_i;
- remain in IDLE.
REQ-019 SHALL give the loader priority over fetch in IDLE; a simultaneous inst_req_i.req waits, unacknowledged.
REQ-020 SHALL ignore loader writes to illegal addresses: ld_gnt_o=1, no SRAM access.
REQ-021 SHALL keep ld_gnt_o=0 outside IDLE; the loader holds its request until granted.
REQ-022 IDLE with req=1, legal addr and no loader write SHALL:
- assert sram_en_o with sram_we_o=0 in that cycle (t);
- go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-023 WAIT SHALL count WAIT_CYCLES cycles and then go to RESP; the SRAM read result is held internally.
REQ-024 RESP SHALL assert ack=1, error=0, data=read word, exactly at cycle t+1+WAIT_CYCLES, then return to IDLE.
REQ-025 IDLE with req=1 and illegal addr SHALL:
- not access the SRAM;
- go to ERR, which asserts ack=1, error=1, data=0 at t+1, then returns to IDLE.
REQ-026 SHALL not sample req in RESP or ERR; a held req after ack is treated as a new request only from the following IDLE cycle.
REQ-027 SHALL drive ack=0, error=0, data=0 in every cycle other than RESP/ERR.
REQ-028 SHALL sustain peak throughput of one fetch per 2+WAIT_CYCLES cycles.

Reset
REQ-029 rst_ni low SHALL immediately do all of the following:
- force IDLE and clear the wait counter and the data hold register;
- drive ack/error/ld_gnt_o/sram_en_o/sram_we_o = 0, data = 0.
REQ-030 Reset during WAIT/RESP SHALL abandon the fetch with no ack; the first post-reset request is handled normally.

Structure
REQ-031 SHALL have DRCP_PKG hold the following, and SHALL use inst_req_t/inst_ack_t unchanged from DRCP_PKG:
- ITCM_ADDR_W = $clog2(ITCM_SIZE/4) = 14;
- the FSM state enum itcm_rsp_state_t.
REQ-032 SHALL have one sub-module, itcm_sram: a behavioural single-port 1-cycle-read SRAM used by the bench; not instantiated inside itcm_inst_rsp.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=0, SRAM word 0 = 0x00000013, req addr 0x10000 at t -> ack=1, error=0, data=0x00000013 at t+1, IDLE at t+2.
REQ-034 SHALL cover: WAIT_CYCLES=2, addr 0x1fffc -> sram_addr_o=0x3fff at t, ack at t+3 with stored data, no ack at t+1/t+2.
REQ-035 SHALL cover: addr 0x20000, then addr 0x10002 -> each yields ack=1, error=1, data=0 one cycle later with sram_en_o never asserted.
REQ-036 SHALL cover: ld_we_i with addr 0x10004, data 0xDEADBEEF, and fetch req in the same cycle -> ld_gnt_o=1, SRAM write, fetch acked later with data 0xDEADBEEF.
REQ-037 SHALL cover: rst_ni pulsed low during WAIT (WAIT_CYCLES=3) -> outputs zero immediately, no ack, next fetch correct.
REQ-038 SHALL cover: req held high for 6 cycles on a single addr, WAIT_CYCLES=0 -> acks at cycles 1,3,5 exactly, never consecutive.
